// File: rtl/canvas_cell_reader.sv
// Scans the 32x32 1-bit canvas cell by cell and streams a set-pixel count per cell.
// Define CANVAS_BBOX_EN to add bounding-box outputs covering every set pixel seen in a scan.
module canvas_cell_reader #(
  parameter  int CELL_LOG2 = 2,
  localparam int GRID_W    = 5 - CELL_LOG2,
  localparam int CNT_W     = 2 * CELL_LOG2 + 1,
  localparam int IDX_W     = 2 * GRID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [9:0]       rd_addr,
  input  logic             rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
`ifdef CANVAS_BBOX_EN
  ,
  output logic [4:0]       bbox_xmin,
  output logic [4:0]       bbox_xmax,
  output logic [4:0]       bbox_ymin,
  output logic [4:0]       bbox_ymax,
  output logic             bbox_empty
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [GRID_W-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [CELL_LOG2-1:0] px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic                 rd_en_q;
  logic                 cell_last;

  assign cell_last = (&cx_q) && (&cy_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      acc_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      acc_q   <= acc_d;
      rd_en_q <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    px_d    = px_q;
    py_d    = py_q;
    acc_d   = acc_q;
    // Data lags the address by one cycle, so the count trails rd_en into DRAIN.
    if (rd_en_q && rd_data) acc_d = acc_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = '0;
          cy_d    = '0;
          px_d    = '0;
          py_d    = '0;
          acc_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        px_d = px_q + 1'b1;
        if (&px_q) py_d = py_q + 1'b1;
        if ((&px_q) && (&py_q)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready) begin
          if (cell_last) begin
            state_d = S_DONE;
          end else begin
            cx_d = cx_q + 1'b1;
            if (&cx_q) cy_d = cy_q + 1'b1;
            acc_d   = '0;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_en     = (state_q == S_READ);
  assign rd_addr   = {cy_q, py_q, cx_q, px_q};
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = acc_q;
  assign out_index = {cy_q, cx_q};
  assign out_last  = (state_q == S_EMIT) && cell_last;

`ifdef CANVAS_BBOX_EN
  logic [9:0] rd_addr_q;
  logic [4:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic       empty_q;
  logic [4:0] pix_x, pix_y;

  assign pix_x = rd_addr_q[4:0];
  assign pix_y = rd_addr_q[9:5];

  // Trackers follow the live scan; the published box only changes on DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      xmin_q     <= 5'd31;
      xmax_q     <= 5'd0;
      ymin_q     <= 5'd31;
      ymax_q     <= 5'd0;
      empty_q    <= 1'b1;
      bbox_xmin  <= 5'd31;
      bbox_xmax  <= 5'd0;
      bbox_ymin  <= 5'd31;
      bbox_ymax  <= 5'd0;
      bbox_empty <= 1'b1;
    end else begin
      rd_addr_q <= rd_addr;
      if (state_q == S_IDLE && start) begin
        xmin_q  <= 5'd31;
        xmax_q  <= 5'd0;
        ymin_q  <= 5'd31;
        ymax_q  <= 5'd0;
        empty_q <= 1'b1;
      end else if (rd_en_q && rd_data) begin
        if (pix_x < xmin_q) xmin_q <= pix_x;
        if (pix_x > xmax_q) xmax_q <= pix_x;
        if (pix_y < ymin_q) ymin_q <= pix_y;
        if (pix_y > ymax_q) ymax_q <= pix_y;
        empty_q <= 1'b0;
      end
      if (state_q == S_DONE) begin
        bbox_xmin  <= xmin_q;
        bbox_xmax  <= xmax_q;
        bbox_ymin  <= ymin_q;
        bbox_ymax  <= ymax_q;
        bbox_empty <= empty_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_canvas_cell_reader.sv
// Scoreboard bench for canvas_cell_reader: canvas model, expected-cell queue, decoupled monitor.
module tb_canvas_cell_reader;
  localparam int CL    = 2;
  localparam int GRID  = 8;
  localparam int CNT_W = 5;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, rd_en, out_valid, out_last;
  logic [9:0]       rd_addr;
  logic             rd_data = 1'b0;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] out_data;
  logic [IDX_W-1:0] out_index;
`ifdef CANVAS_BBOX_EN
  logic [4:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic       bbox_empty;
`endif

  canvas_cell_reader #(.CELL_LOG2(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
`ifdef CANVAS_BBOX_EN
    , .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin),
    .bbox_ymax(bbox_ymax), .bbox_empty(bbox_empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int cnt; bit last;} exp_t;
  exp_t exp_q[$];
  bit   mem [1024];
  int   tests = 0, fails = 0;
  int   cyc = 0, done_cnt = 0, sum_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every accepted transfer is matched against the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer actual=idx%0d required=none", out_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] xfer idx=%0d cnt=%0d last=%0d", out_index, out_data, out_last);
        chk("out_index", int'(out_index), e.idx);
        chk("out_data", int'(out_data), e.cnt);
        chk("out_last", int'(out_last), int'(e.last));
        sum_cnt += int'(out_data);
      end
    end
  end

  task automatic push_scan();
    for (int idx = 0; idx < GRID * GRID; idx++) begin
      exp_t e;
      int cy, cx;
      cy = idx / GRID;
      cx = idx % GRID;
      e.idx = idx;
      e.cnt = 0;
      for (int py = 0; py < 4; py++)
        for (int px = 0; px < 4; px++)
          e.cnt += int'(mem[(cy * 4 + py) * 32 + cx * 4 + px]);
      e.last = (idx == GRID * GRID - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_scan(input string name, input int exp_cycles);
    int s, dcyc, d0;
    bit seen;
    push_scan();
    d0 = done_cnt;
    sum_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc - s;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_done_cycle"}, dcyc, exp_cycles);
    repeat (3) @(negedge clk);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    exp_q.delete();
  endtask

  task automatic stall_cell3();
    bit found = 1'b0;
    int d0, i0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_index == 6'd3 && !rd_en && !out_valid && busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_found_drain3", int'(found), 1);
    out_ready = 1'b0;
    @(negedge clk);
    d0 = int'(out_data);
    i0 = int'(out_index);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), d0);
      chk("stall_index", int'(out_index), i0);
      chk("stall_no_rd", int'(rd_en), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("cell4_rd_en", int'(rd_en), 1);
    chk("cell4_rd_addr", int'(rd_addr), 16);
  endtask

  task automatic pulse_start_late();
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_index", int'(out_index), 0);

    run_scan("empty", 1152);
`ifdef CANVAS_BBOX_EN
    chk("bbox_empty_e", int'(bbox_empty), 1);
    chk("bbox_xmin_e", int'(bbox_xmin), 31);
    chk("bbox_xmax_e", int'(bbox_xmax), 0);
`endif

    for (int a = 0; a < 1024; a++) mem[a] = 1'b1;
    run_scan("full", 1152);
    chk("full_sum", sum_cnt, 1024);

    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
    mem[5 * 32 + 9] = 1'b1;
    run_scan("single", 1152);
    chk("single_sum", sum_cnt, 1);

    for (int a = 0; a < 1024; a++) mem[a] = ((a % 3) == 0) || (a[9:5] == 5'd2);
    fork
      run_scan("stall", 1162);
      stall_cell3();
    join

    fork
      run_scan("busy_start", 1152);
      pulse_start_late();
    join

    push_scan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_rd_addr", int'(rd_addr), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_index", int'(out_index), 0);
    exp_q.delete();
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("arst_no_done", done_cnt - d0, 0);
    end
    run_scan("rescan", 1152);

`ifdef CANVAS_BBOX_EN
    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
    mem[7 * 32 + 3]   = 1'b1;
    mem[28 * 32 + 20] = 1'b1;
    run_scan("bbox", 1152);
    chk("bbox_xmin", int'(bbox_xmin), 3);
    chk("bbox_xmax", int'(bbox_xmax), 20);
    chk("bbox_ymin", int'(bbox_ymin), 7);
    chk("bbox_ymax", int'(bbox_ymax), 28);
    chk("bbox_empty", int'(bbox_empty), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
